conbus_rr: RTL

//  Parametrised Wishbone shared-bus interconnect: NM masters, NS slaves, one shared path.

---
 rtl/conbus_rr.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/conbus_rr.sv
// conbus_rr - shared-bus Wishbone interconnect with a registered round-robin
// arbiter, a per-slave address decoder and error signalling. Error signalling
// covers decode misses, slave errors and a watchdog timeout, so that a master
// never waits forever.
//
// Ports
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   m_adr_i .. m_stb_i        packed per-master request fields, master k at [k*W +: W]
//   m_dat_o                   read data shared by all masters
//   m_ack_o, m_err_o          per-master handshake, only the granted master sees it
//   s_adr_o .. s_cyc_o        shared slave bus carrying the granted master's fields
//   s_stb_o                   per-slave decoded strobe
//   s_dat_i, s_ack_i, s_err_i packed per-slave responses
module conbus_rr #(
    parameter int NM      = 5,
    parameter int NS      = 5,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SAW     = 4,
    parameter logic [NS*SAW-1:0] S_ADDRS = {4'h4, 4'h3, 4'h2, 4'h1, 4'h0},
    parameter int TIMEOUT = 255
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [NM*AW-1:0]       m_adr_i,
    input  logic [NM*DW-1:0]       m_dat_i,
    input  logic [NM*(DW/8)-1:0]   m_sel_i,
    input  logic [NM*3-1:0]        m_cti_i,
    input  logic [NM-1:0]          m_we_i,
    input  logic [NM-1:0]          m_cyc_i,
    input  logic [NM-1:0]          m_stb_i,
    output logic [DW-1:0]          m_dat_o,
    output logic [NM-1:0]          m_ack_o,
    output logic [NM-1:0]          m_err_o,
    output logic [AW-1:0]          s_adr_o,
    output logic [DW-1:0]          s_dat_o,
    output logic [DW/8-1:0]        s_sel_o,
    output logic [2:0]             s_cti_o,
    output logic                   s_we_o,
    output logic                   s_cyc_o,
    output logic [NS-1:0]          s_stb_o,
    input  logic [NS*DW-1:0]       s_dat_i,
    input  logic [NS-1:0]          s_ack_i,
    input  logic [NS-1:0]          s_err_i
);

    localparam int LW  = (NM > 1) ? $clog2(NM) : 1;
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state, state_nx;
    logic [NM-1:0]  gnt, gnt_nx;
    logic [LW-1:0]  last, last_nx, winner;
    logic [WDW-1:0] wd_cnt, wd_nx;
    logic           err_pend, err_pend_nx;
    logic           gstb, miss, ack_any, err_any;
    logic [NS-1:0]  match, sel;

    // AND-OR mux of the granted master onto the shared slave bus; with no
    // grant every field collapses to zero.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        gstb    = 1'b0;
        for (int k = 0; k < NM; k++) begin
            if (gnt[k]) begin
                s_adr_o = s_adr_o | m_adr_i[k*AW +: AW];
                s_dat_o = s_dat_o | m_dat_i[k*DW +: DW];
                s_sel_o = s_sel_o | m_sel_i[k*(DW/8) +: DW/8];
                s_cti_o = s_cti_o | m_cti_i[k*3 +: 3];
                s_we_o  = s_we_o  | m_we_i[k];
                s_cyc_o = s_cyc_o | m_cyc_i[k];
                gstb    = gstb    | m_stb_i[k];
            end
        end
    end

    // Address decode on the top SAW bits. The descending scan lets the lowest
    // matching slave overwrite higher ones, so overlapping bases stay one-hot.
    // A pending error masks the strobe so the slave does not see the access
    // that is being failed.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NS; i++) begin
            match[i] = (s_adr_o[AW-1 -: SAW] == S_ADDRS[i*SAW +: SAW]);
        end
        for (int i = NS - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
        s_stb_o = sel & {NS{s_cyc_o & gstb & ~err_pend}};
        miss    = s_cyc_o & gstb & ~(|match) & ~err_pend;
        ack_any = |(s_ack_i & s_stb_o);
        err_any = |(s_err_i & s_stb_o);
        m_dat_o = '0;
        for (int i = 0; i < NS; i++) begin
            if (s_stb_o[i]) begin
                m_dat_o = m_dat_o | s_dat_i[i*DW +: DW];
            end
        end
        m_ack_o = gnt & {NM{ack_any}};
        m_err_o = gnt & {NM{err_any | err_pend}};
    end

    // Round-robin pick: first requester after the previous winner, wrapping.
    always_comb begin
        winner = last;
        for (int i = NM; i >= 1; i--) begin
            if (m_cyc_i[(int'(last) + i) % NM]) begin
                winner = LW'((int'(last) + i) % NM);
            end
        end
    end

    // Arbiter FSM: a grant is held for the whole cyc tenure and released into
    // IDLE, which gives one dead cycle between owners.
    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        last_nx  = last;
        case (state)
            IDLE: begin
                if (|m_cyc_i) begin
                    gnt_nx   = NM'(1) << winner;
                    last_nx  = winner;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (!s_cyc_o) begin
                    gnt_nx   = '0;
                    state_nx = IDLE;
                end
            end
            default: begin
                gnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // Watchdog and the one-cycle error pulse. An unanswered strobe counts up,
    // and reaching TIMEOUT-1 raises the same pulse that a decode miss raises.
    // A response in that cycle takes precedence because the count only
    // advances when no ack or err is present.
    always_comb begin
        wd_nx       = '0;
        err_pend_nx = 1'b0;
        if (!err_pend) begin
            if (miss) begin
                err_pend_nx = 1'b1;
            end else if ((|s_stb_o) && !ack_any && !err_any) begin
                if (wd_cnt == WDW'(TIMEOUT - 1)) begin
                    err_pend_nx = 1'b1;
                end else begin
                    wd_nx = wd_cnt + WDW'(1);
                end
            end
        end
    end

    // State registers; reset makes master 0 the first winner.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            gnt      <= '0;
            last     <= LW'(NM - 1);
            wd_cnt   <= '0;
            err_pend <= 1'b0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            last     <= last_nx;
            wd_cnt   <= wd_nx;
            err_pend <= err_pend_nx;
        end
    end

endmodule
